// File: rtl/dram_axi_burst_engine_if.sv
// AXI4 master/slave bundle for the m00 DRAM port of the burst engine.
// The master modport is used by the engine; the slave modport by memory models.
interface dram_axi_burst_engine_if #(
    parameter int data_width = 32,
    parameter int addr_width = 32,
    parameter int id_width   = 6
) ();

    // write address channel
    logic [id_width-1:0]     awid;
    logic [addr_width-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    // write data channel
    logic [id_width-1:0]     wid;
    logic [data_width-1:0]   wdata;
    logic [data_width/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    // write response channel
    logic [id_width-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    // read address channel
    logic [id_width-1:0]     arid;
    logic [addr_width-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;

    // read data channel
    logic [id_width-1:0]     rid;
    logic [data_width-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/dram_axi_burst_engine.sv
// Host-programmable AXI4 burst master: one command at a time, either writes a
// seed+beat pattern burst or reads a burst back and counts pattern mismatches,
// then reports a status record.
module dram_axi_burst_engine #(
    parameter int axi_data_width = 32,
    parameter int axi_addr_width = 32,
    parameter int axi_id         = 0,
    parameter int axi_id_width   = 6
) (
    input  logic                      aclk,
    input  logic                      reset,

    input  logic                      cmd_v_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [axi_addr_width-1:0] cmd_addr_i,
    input  logic [7:0]                cmd_len_i,
    input  logic [axi_data_width-1:0] cmd_seed_i,

    output logic                      resp_v_o,
    input  logic                      resp_ready_i,
    output logic [8:0]                resp_err_cnt_o,
    output logic                      resp_axi_err_o,
    output logic                      resp_boundary_err_o,

    dram_axi_burst_engine_if.master   m00_axi
);

    localparam int              bytes_per_beat = axi_data_width / 8;
    localparam int              size_log       = $clog2(bytes_per_beat);
    localparam logic [2:0]      axi_size       = 3'(size_log);
    localparam logic [1:0]      burst_incr     = 2'b01;
    localparam logic [3:0]      cache_val      = 4'b0011;
    localparam logic [axi_id_width-1:0] id_val = axi_id_width'(axi_id);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_RESP
    } state_t;

    state_t                    state;

    // latched command
    logic [axi_addr_width-1:0] addr_q;
    logic [7:0]                len_q;
    logic [axi_data_width-1:0] seed_q;
    logic [8:0]                beat_q;

    // registered channel outputs
    logic                      awvalid_q;
    logic                      wvalid_q;
    logic [axi_data_width-1:0] wdata_q;
    logic                      wlast_q;
    logic                      bready_q;
    logic                      arvalid_q;
    logic                      rready_q;
    logic                      cmd_ready_q;
    logic                      resp_v_q;
    logic [8:0]                err_cnt_q;
    logic                      axi_err_q;
    logic                      boundary_q;

    // command address with the sub-beat byte offset dropped
    logic [axi_addr_width-1:0] cmd_addr_aligned;
    logic [13:0]               burst_bytes;
    logic [13:0]               burst_end;
    logic                      crosses_4k;

    logic [axi_data_width-1:0] expected_rdata;
    logic                      rresp_err;
    logic                      beat_is_last;

    assign cmd_addr_aligned = {cmd_addr_i[axi_addr_width-1:size_log], {size_log{1'b0}}};
    assign burst_bytes      = (14'(cmd_len_i) + 14'd1) << size_log;
    assign burst_end        = 14'(cmd_addr_aligned[11:0]) + burst_bytes;
    assign crosses_4k       = (burst_end > 14'd4096);

    assign expected_rdata   = seed_q + axi_data_width'(beat_q);
    assign rresp_err        = (m00_axi.rresp != 2'b00);
    assign beat_is_last     = (beat_q == {1'b0, len_q});

    // write address channel: fields come from the latched command
    assign m00_axi.awid     = id_val;
    assign m00_axi.awaddr   = addr_q;
    assign m00_axi.awlen    = len_q;
    assign m00_axi.awsize   = axi_size;
    assign m00_axi.awburst  = burst_incr;
    assign m00_axi.awlock   = 1'b0;
    assign m00_axi.awcache  = cache_val;
    assign m00_axi.awprot   = 3'b000;
    assign m00_axi.awqos    = 4'b0000;
    assign m00_axi.awvalid  = awvalid_q;

    // write data channel
    assign m00_axi.wid      = id_val;
    assign m00_axi.wdata    = wdata_q;
    assign m00_axi.wstrb    = '1;
    assign m00_axi.wlast    = wlast_q;
    assign m00_axi.wvalid   = wvalid_q;

    assign m00_axi.bready   = bready_q;

    // read address channel
    assign m00_axi.arid     = id_val;
    assign m00_axi.araddr   = addr_q;
    assign m00_axi.arlen    = len_q;
    assign m00_axi.arsize   = axi_size;
    assign m00_axi.arburst  = burst_incr;
    assign m00_axi.arlock   = 1'b0;
    assign m00_axi.arcache  = cache_val;
    assign m00_axi.arprot   = 3'b000;
    assign m00_axi.arqos    = 4'b0000;
    assign m00_axi.arvalid  = arvalid_q;

    assign m00_axi.rready   = rready_q;

    assign cmd_ready_o         = cmd_ready_q;
    assign resp_v_o            = resp_v_q;
    assign resp_err_cnt_o      = err_cnt_q;
    assign resp_axi_err_o      = axi_err_q;
    assign resp_boundary_err_o = boundary_q;

    // command sequencer: every output is a register updated only on the handshakes that move it
    always_ff @(posedge aclk) begin
        if (reset) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            seed_q      <= '0;
            beat_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            resp_v_q    <= 1'b0;
            err_cnt_q   <= '0;
            axi_err_q   <= 1'b0;
            boundary_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_v_i) begin
                        addr_q      <= cmd_addr_aligned;
                        len_q       <= cmd_len_i;
                        seed_q      <= cmd_seed_i;
                        beat_q      <= '0;
                        err_cnt_q   <= '0;
                        axi_err_q   <= 1'b0;
                        boundary_q  <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        if (crosses_4k) begin
                            // an illegal burst is reported without touching the bus
                            boundary_q <= 1'b1;
                            resp_v_q   <= 1'b1;
                            state      <= S_RESP;
                        end else if (cmd_write_i) begin
                            awvalid_q <= 1'b1;
                            state     <= S_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= S_AR;
                        end
                    end
                end

                S_AW: begin
                    if (m00_axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= seed_q;
                        wlast_q   <= (len_q == 8'd0);
                        state     <= S_W;
                    end
                end

                S_W: begin
                    if (m00_axi.wready) begin
                        beat_q <= beat_q + 9'd1;
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state    <= S_B;
                        end else begin
                            wdata_q <= wdata_q + axi_data_width'(1);
                            wlast_q <= ((beat_q + 9'd1) == {1'b0, len_q});
                        end
                    end
                end

                S_B: begin
                    if (m00_axi.bvalid) begin
                        bready_q  <= 1'b0;
                        axi_err_q <= axi_err_q | (m00_axi.bresp != 2'b00);
                        resp_v_q  <= 1'b1;
                        state     <= S_RESP;
                    end
                end

                S_AR: begin
                    if (m00_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= S_R;
                    end
                end

                S_R: begin
                    if (m00_axi.rvalid) begin
                        if ((m00_axi.rdata != expected_rdata) && (err_cnt_q != 9'h1FF)) begin
                            err_cnt_q <= err_cnt_q + 9'd1;
                        end
                        beat_q <= beat_q + 9'd1;
                        if (m00_axi.rlast) begin
                            // rlast anywhere but the final beat is a protocol error
                            axi_err_q <= axi_err_q | rresp_err | !beat_is_last;
                            rready_q  <= 1'b0;
                            resp_v_q  <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            // final beat without rlast: flag it and keep draining
                            axi_err_q <= axi_err_q | rresp_err | beat_is_last;
                        end
                    end
                end

                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_v_q    <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_axi_burst_engine.sv
// Directed bench for dram_axi_burst_engine with a stallable AXI memory model.
module tb_dram_axi_burst_engine;

    localparam int dw  = 32;
    localparam int aw  = 32;
    localparam int idw = 6;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_v = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] cmd_seed = '0;
    logic        cmd_ready;
    logic        resp_v;
    logic        resp_ready = 1'b0;
    logic [8:0]  resp_err_cnt;
    logic        resp_axi_err;
    logic        resp_boundary_err;

    int total = 0;
    int bad   = 0;

    // memory model configuration, written only by the stimulus block
    int          stall_max   = 0;
    logic [1:0]  bresp_cfg   = 2'b00;
    int          early_beat  = -1;
    int          corrupt_beat = -1;
    logic [31:0] corrupt_val = '0;

    // monitor-owned state
    logic [31:0] mem [0:4095];
    logic [31:0] w_log_data [0:1023];
    logic        w_log_last [0:1023];
    int aw_cnt = 0, ar_cnt = 0, w_cnt = 0, r_cnt = 0, awv_cnt = 0, arv_cnt = 0, stab_viol = 0;
    int wr_ptr = 0;
    logic [31:0] aw_addr_l = '0, ar_addr_l = '0;
    logic [7:0]  aw_len_l = '0, ar_len_l = '0;
    logic [2:0]  aw_size_l = '0;
    logic [1:0]  aw_burst_l = '0;
    logic [3:0]  aw_cache_l = '0;
    logic aw_hs = 0, w_hs = 0, w_last_s = 0, b_hs = 0, ar_hs = 0, r_hs = 0, r_last_s = 0;
    logic aw_hold = 0, w_hold = 0, ar_hold = 0, rs_hold = 0;
    logic [31:0] aw_addr_h = '0, w_data_h = '0, ar_addr_h = '0;
    logic [7:0]  aw_len_h = '0, ar_len_h = '0;
    logic        w_last_h = 0;
    logic [10:0] rs_fields_h = '0;

    // model-driver-owned state
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0, r_beat = 0;
    logic b_pend = 0, r_active = 0;
    logic [31:0] r_base = '0;
    logic [7:0]  r_len = '0;

    always #5 aclk = ~aclk;

    dram_axi_burst_engine_if #(.data_width(dw), .addr_width(aw), .id_width(idw)) m00 ();

    dram_axi_burst_engine #(
        .axi_data_width(dw),
        .axi_addr_width(aw),
        .axi_id(0),
        .axi_id_width(idw)
    ) dut (
        .aclk(aclk),
        .reset(reset),
        .cmd_v_i(cmd_v),
        .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr),
        .cmd_len_i(cmd_len),
        .cmd_seed_i(cmd_seed),
        .resp_v_o(resp_v),
        .resp_ready_i(resp_ready),
        .resp_err_cnt_o(resp_err_cnt),
        .resp_axi_err_o(resp_axi_err),
        .resp_boundary_err_o(resp_boundary_err),
        .m00_axi(m00.master)
    );

    function automatic int rnd();
        if (stall_max == 0) return 0;
        return int'($urandom_range(stall_max, 0));
    endfunction

    // snapshot handshakes at the active edge, log traffic and check that stalled fields hold
    always @(posedge aclk) begin
        aw_hs    = m00.awvalid && m00.awready;
        w_hs     = m00.wvalid && m00.wready;
        w_last_s = m00.wlast;
        b_hs     = m00.bvalid && m00.bready;
        ar_hs    = m00.arvalid && m00.arready;
        r_hs     = m00.rvalid && m00.rready;
        r_last_s = m00.rlast;
        if (reset) begin
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_hold = 0; w_hold = 0; ar_hold = 0; rs_hold = 0;
        end else begin
            if (aw_hold && !(m00.awvalid && m00.awaddr == aw_addr_h && m00.awlen == aw_len_h)) stab_viol++;
            if (w_hold && !(m00.wvalid && m00.wdata == w_data_h && m00.wlast == w_last_h)) stab_viol++;
            if (ar_hold && !(m00.arvalid && m00.araddr == ar_addr_h && m00.arlen == ar_len_h)) stab_viol++;
            if (rs_hold && !(resp_v && {resp_err_cnt, resp_axi_err, resp_boundary_err} == rs_fields_h)) stab_viol++;
            aw_hold = m00.awvalid && !m00.awready;
            aw_addr_h = m00.awaddr; aw_len_h = m00.awlen;
            w_hold = m00.wvalid && !m00.wready;
            w_data_h = m00.wdata; w_last_h = m00.wlast;
            ar_hold = m00.arvalid && !m00.arready;
            ar_addr_h = m00.araddr; ar_len_h = m00.arlen;
            rs_hold = resp_v && !resp_ready;
            rs_fields_h = {resp_err_cnt, resp_axi_err, resp_boundary_err};
            if (m00.awvalid) awv_cnt++;
            if (m00.arvalid) arv_cnt++;
            if (aw_hs) begin
                aw_cnt++;
                aw_addr_l = m00.awaddr; aw_len_l = m00.awlen; aw_size_l = m00.awsize;
                aw_burst_l = m00.awburst; aw_cache_l = m00.awcache;
                wr_ptr = 0;
            end
            if (w_hs) begin
                if (w_cnt < 1024) begin
                    w_log_data[w_cnt] = m00.wdata;
                    w_log_last[w_cnt] = m00.wlast;
                end
                mem[(int'(aw_addr_l[13:2]) + wr_ptr) & 4095] = m00.wdata;
                wr_ptr++;
                w_cnt++;
            end
            if (ar_hs) begin
                ar_cnt++;
                ar_addr_l = m00.araddr; ar_len_l = m00.arlen;
            end
            if (r_hs) r_cnt++;
        end
    end

    // memory slave: drives its outputs on the falling edge with random stalls
    always @(negedge aclk) begin
        if (reset) begin
            m00.awready = 0; m00.wready = 0; m00.arready = 0;
            m00.bvalid = 0; m00.bresp = 0; m00.bid = 0;
            m00.rvalid = 0; m00.rdata = 0; m00.rresp = 0; m00.rlast = 0; m00.rid = 0;
            aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
            b_pend = 0; r_active = 0; r_beat = 0;
        end else begin
            if (aw_hs) aw_dly = rnd();
            if (aw_dly > 0) begin m00.awready = 0; aw_dly--; end else m00.awready = 1;
            if (w_hs) w_dly = rnd();
            if (w_dly > 0) begin m00.wready = 0; w_dly--; end else m00.wready = 1;
            if (ar_hs) ar_dly = rnd();
            if (ar_dly > 0) begin m00.arready = 0; ar_dly--; end else m00.arready = 1;

            if (b_hs) m00.bvalid = 0;
            if (w_hs && w_last_s) begin b_pend = 1; b_dly = rnd(); end
            if (b_pend) begin
                if (b_dly > 0) b_dly--;
                else begin m00.bvalid = 1; m00.bresp = bresp_cfg; b_pend = 0; end
            end

            if (ar_hs) begin
                r_base = ar_addr_l; r_len = ar_len_l; r_beat = 0; r_active = 1; r_dly = rnd();
            end
            if (r_hs) begin
                m00.rvalid = 0;
                r_beat++;
                r_dly = rnd();
                if (r_last_s) r_active = 0;
            end
            if (r_active && !m00.rvalid) begin
                if (r_dly > 0) r_dly--;
                else begin
                    m00.rvalid = 1;
                    m00.rresp  = 2'b00;
                    m00.rdata  = (r_beat == corrupt_beat) ? corrupt_val
                                 : mem[(int'(r_base[13:2]) + r_beat) & 4095];
                    m00.rlast  = (r_beat == int'(r_len)) || (r_beat == early_beat);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [31:0] seed);
        int n;
        @(negedge aclk);
        cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_seed = seed; cmd_v = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge aclk); n++; end
        checkOutput("cmd_accept_timeout", 64'(n >= 1000), 0);
        @(negedge aclk);
        cmd_v = 1'b0;
    endtask

    task automatic waitResp(output int cyc, output logic [8:0] err, output logic axi, output logic bnd);
        int d;
        cyc = 0;
        while (!resp_v && cyc < 20000) begin @(negedge aclk); cyc++; end
        checkOutput("resp_timeout", 64'(resp_v), 1);
        err = resp_err_cnt; axi = resp_axi_err; bnd = resp_boundary_err;
        d = rnd();
        repeat (d) @(negedge aclk);
        resp_ready = 1'b1;
        @(negedge aclk);
        resp_ready = 1'b0;
    endtask

    // directed test sequence
    initial begin
        int cyc, w0, r0, aw0, ar0, awv0, arv0, nbad, n;
        logic [8:0] err;
        logic axi, bnd;
        logic [3:0] lastv;

        // reset values
        reset = 1'b1;
        repeat (3) @(negedge aclk);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 1);
        checkOutput("rst_valids", 64'({m00.awvalid, m00.wvalid, m00.arvalid, m00.bready, m00.rready, resp_v}), 0);
        checkOutput("rst_resp_fields", 64'({resp_err_cnt, resp_axi_err, resp_boundary_err}), 0);
        reset = 1'b0;

        // write 0x1000 len 3 seed 0xA0
        w0 = w_cnt; aw0 = aw_cnt;
        applyStimulus(1'b1, 32'h1000, 8'd3, 32'hA0);
        waitResp(cyc, err, axi, bnd);
        checkOutput("t1_aw_count", 64'(aw_cnt - aw0), 1);
        checkOutput("t1_awaddr", 64'(aw_addr_l), 64'h1000);
        checkOutput("t1_awlen", 64'(aw_len_l), 3);
        checkOutput("t1_awsize", 64'(aw_size_l), 2);
        checkOutput("t1_awburst_cache", 64'({aw_burst_l, aw_cache_l}), 64'h13);
        checkOutput("t1_w_count", 64'(w_cnt - w0), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t1_wdata%0d", i), 64'(w_log_data[w0 + i]), 64'(32'hA0 + i));
            lastv[i] = w_log_last[w0 + i];
        end
        checkOutput("t1_wlast_pattern", 64'(lastv), 64'h8);
        checkOutput("t1_resp", 64'({err, axi, bnd}), 0);

        // read back with beat 2 corrupted, unaligned address
        corrupt_beat = 2; corrupt_val = 32'hFF;
        r0 = r_cnt;
        applyStimulus(1'b0, 32'h1002, 8'd3, 32'hA0);
        waitResp(cyc, err, axi, bnd);
        corrupt_beat = -1;
        checkOutput("t2_araddr_aligned", 64'(ar_addr_l), 64'h1000);
        checkOutput("t2_r_count", 64'(r_cnt - r0), 4);
        checkOutput("t2_err_cnt", 64'(err), 1);
        checkOutput("t2_axi_err", 64'({axi, bnd}), 0);

        // 4 KB crossing: rejected without bus traffic
        awv0 = awv_cnt; arv0 = arv_cnt;
        applyStimulus(1'b1, 32'h0FF8, 8'd3, 32'h1);
        waitResp(cyc, err, axi, bnd);
        checkOutput("t3_boundary", 64'(bnd), 1);
        checkOutput("t3_resp_latency", 64'(cyc <= 1), 1);
        checkOutput("t3_no_addr_valid", 64'((awv_cnt - awv0) + (arv_cnt - arv0)), 0);
        checkOutput("t3_other_fields", 64'({err, axi}), 0);

        // ends exactly on the 4 KB line: legal
        aw0 = aw_cnt;
        applyStimulus(1'b1, 32'h0FF0, 8'd3, 32'h10);
        waitResp(cyc, err, axi, bnd);
        checkOutput("t3b_boundary_edge", 64'({err, axi, bnd}), 0);
        checkOutput("t3b_aw_count", 64'(aw_cnt - aw0), 1);

        // SLVERR on the write response
        bresp_cfg = 2'b10;
        applyStimulus(1'b1, 32'h2000, 8'd0, 32'h5);
        waitResp(cyc, err, axi, bnd);
        bresp_cfg = 2'b00;
        checkOutput("t5_bresp_axi_err", 64'({err, axi, bnd}), 64'h2);

        // early rlast at beat 1 of a len 3 read
        early_beat = 1;
        r0 = r_cnt;
        applyStimulus(1'b0, 32'h1000, 8'd3, 32'hA0);
        waitResp(cyc, err, axi, bnd);
        early_beat = -1;
        checkOutput("t5_early_rlast_axi_err", 64'({err, axi, bnd}), 64'h2);
        checkOutput("t5_early_r_count", 64'(r_cnt - r0), 2);
        checkOutput("t5_back_to_idle", 64'(cmd_ready), 1);

        // long bursts with random stalls on every channel
        stall_max = 5;
        w0 = w_cnt;
        applyStimulus(1'b1, 32'h1000, 8'd255, 32'h12345678);
        waitResp(cyc, err, axi, bnd);
        checkOutput("t4_w_count", 64'(w_cnt - w0), 256);
        nbad = 0;
        for (int i = 0; i < 256; i++) begin
            if (w_log_data[w0 + i] !== 32'h12345678 + 32'(i)) nbad++;
            if (w_log_last[w0 + i] !== (i == 255)) nbad++;
        end
        checkOutput("t4_wbeats_bad", 64'(nbad), 0);
        checkOutput("t4_write_resp", 64'({err, axi, bnd}), 0);
        r0 = r_cnt; ar0 = ar_cnt;
        applyStimulus(1'b0, 32'h1000, 8'd255, 32'h12345678);
        waitResp(cyc, err, axi, bnd);
        checkOutput("t4_r_count", 64'(r_cnt - r0), 256);
        checkOutput("t4_ar_len", 64'({ar_len_l, 24'(ar_cnt - ar0)}), 64'hFF000001);
        checkOutput("t4_read_resp", 64'({err, axi, bnd}), 0);
        stall_max = 0;

        // reset in the middle of the write data phase
        applyStimulus(1'b1, 32'h3000, 8'd7, 32'h50);
        n = 0;
        while (!(m00.wvalid && m00.wdata == 32'h52) && n < 100) begin @(negedge aclk); n++; end
        checkOutput("t6_reach_beat2", 64'(n < 100), 1);
        reset = 1'b1;
        @(negedge aclk);
        checkOutput("t6_valids_after_rst", 64'({m00.awvalid, m00.wvalid, m00.arvalid, m00.bready, m00.rready, resp_v}), 0);
        checkOutput("t6_cmd_ready_after_rst", 64'(cmd_ready), 1);
        reset = 1'b0;
        w0 = w_cnt;
        applyStimulus(1'b1, 32'h3100, 8'd1, 32'h7);
        waitResp(cyc, err, axi, bnd);
        checkOutput("t6_post_rst_resp", 64'({err, axi, bnd}), 0);
        checkOutput("t6_post_rst_wbeats", 64'({w_log_data[w0], w_log_data[w0 + 1]}), 64'h0000000700000008);
        checkOutput("t6_post_rst_wcount", 64'(w_cnt - w0), 2);

        checkOutput("stall_stability_violations", 64'(stab_viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/dram_axi_burst_engine.md
Name: dram_axi_burst_engine

Overview:
- Host-programmable AXI4 burst master. Sits between the PS-facing CSR logic and the m00_axi DRAM port of the Zynq top.
- Accepts one command at a time: write or read, start address, beat count, data seed.
- Write commands emit a deterministic burst pattern; read commands fetch a burst and check it against the same pattern.
- Reports a status record per command, so the PS can exercise DRAM with arbitrary burst shapes.

Parameters:
- axi_data_width, 32, m00 data width in bits; power of two, 32..128.
- axi_addr_width, 32, m00 address width.
- axi_id, 0, constant value driven on awid/arid/wid.

Ports:
- aclk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_write_i  in  1  1 = write burst, 0 = read-and-check burst.
- cmd_addr_i  in  axi_addr_width  start byte address.
- cmd_len_i  in  8  beats minus one (AXI len encoding).
- cmd_seed_i  in  axi_data_width  pattern seed.
- resp_v_o  out  1  status valid.
- resp_ready_i  in  1  status accept.
- resp_err_cnt_o  out  9  count of mismatched read beats.
- resp_axi_err_o  out  1  any bresp/rresp != OKAY.
- resp_boundary_err_o  out  1  command rejected (4 KB crossing).
- m00_axi_aw*/w*/b*/ar*/r*  AXI4 master  widths per the top-level m00 port list  DRAM port.
- Constants: id = axi_id; lock = 0; cache = 4'b0011; prot = 0; qos = 0; burst = INCR; size = log2(axi_data_width/8); wstrb all ones.

Behaviour:
- Handshakes: all valid/ready; a transfer occurs on valid & ready at the aclk edge.
- Reset values: all valids 0, cmd_ready_o 1, resp fields 0, state IDLE.
- Reset mid-burst: returns to IDLE immediately and abandons the burst. The system resets the interconnect together with this block.
- Command latch: on cmd handshake, latch all cmd fields.
  - Low log2(bytes) address bits are forced to 0.
  - Beat counter is cleared; error counter and error flags are cleared.
- Boundary check (IDLE -> RESP directly, no AXI traffic): addr[11:0] + (len+1)*bytes > 4096 sets resp_boundary_err_o = 1.
- States and transitions:
  - IDLE -> AW (write) or AR (read).
  - AW: awvalid = 1, held with stable fields until awready. Then -> W.
  - W: wvalid = 1; wdata = seed + beat (modulo 2^axi_data_width); wlast = (beat == len).
    - On each accepted beat, beat increments.
    - On the last accepted beat -> B.
    - W is never asserted before AW is accepted.
  - B: bready = 1. On bvalid, axi_err |= (bresp != 0). Then -> RESP.
  - AR: arvalid = 1 until arready. Then -> R.
  - R: rready = 1. For each accepted beat:
    - If rdata != seed + beat, err_cnt increments (saturating at 511, unreachable with len <= 255).
    - axi_err |= (rresp != 0).
    - Beat increments.
    - If rlast arrives with beat == len -> RESP.
  - R rlast mismatch: rlast early (beat < len) or missing at beat == len sets axi_err. On early rlast -> RESP; on missing rlast, remain in R draining until rlast.
  - RESP: resp_v_o = 1, fields stable until resp_ready_i. Then -> IDLE.
- Latency: 1 cycle from resp handshake to cmd_ready_o.
- Back-to-back: the next command is accepted in the cycle after the resp handshake.
- Max 1 outstanding transaction; bid/rid are ignored.
- Backpressure: any number of stall cycles on awready/wready/bvalid/arready/rvalid/resp_ready_i is tolerated; outputs stay stable while stalled.

Test Plan:
- Write addr 0x1000, len 3, seed 0xA0 -> one AW (awlen 3, awsize 2); W beats 0xA0, 0xA1, 0xA2, 0xA3 with wlast on beat 3; resp err_cnt 0, axi_err 0.
- Read the same region with seed 0xA0, memory model returns beat 2 as 0xFF -> resp_err_cnt_o = 1, axi_err 0.
- Command addr 0x0FF8, len 3 (32-bit) -> boundary_err = 1, no aw/ar valid observed, resp within 2 cycles.
- Random 0–5 cycle stalls on every ready/valid from the model, write len 255 then read back with the same seed -> 256 beats each, err_cnt 0, AXI fields stable under stall.
- Model returns bresp = SLVERR on write and rlast early at beat 1 of a len 3 read -> axi_err 1 on both responses; engine returns to IDLE.
- Assert reset during W beat 2 -> next cycle all valids 0, cmd_ready_o 1; a subsequent command completes normally.
